// File: rtl/r2r_wave_sequencer.sv
// Periodic 4-bit sample source for the R2R DAC control stage.
// Plays a loadable 16-entry table, a built-in triangle or a built-in square at a divided tick rate.
module r2r_wave_sequencer #(
    parameter int unsigned RATE_W    = 8,
    parameter int unsigned TBL_DEPTH = 16,
    localparam int unsigned IDX_W    = $clog2(TBL_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3:0]        wr_data,
    input  logic [RATE_W-1:0] rate,
    input  logic              rate_load,
    output logic [3:0]        sample,
    output logic              ext_data,
    output logic              sample_strobe,
    output logic              wrap
);

    localparam int unsigned      SMP_W   = 4;
    localparam logic [SMP_W-1:0] SMP_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TBL_DEPTH - 1);

    typedef enum logic [1:0] {
        MODE_TABLE  = 2'b00,
        MODE_TRI    = 2'b01,
        MODE_SQUARE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [RATE_W-1:0] rate_reg, rate_d;
    logic [RATE_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [SMP_W-1:0]  tri_val, tri_d;
    logic              tri_dir, dir_d;
    logic [SMP_W-1:0]  sample_d;
    logic              strobe_d;
    logic              wrap_d;
    logic [SMP_W-1:0]  tbl [TBL_DEPTH];

    mode_e             mode_c;
    logic              active_c;
    logic              tick_c;
    logic [IDX_W-1:0]  idx_inc_c;

    assign mode_c = mode_e'(mode);

    // Next-state: rate load has priority over the tick; table reads see pre-write contents.
    always_comb begin
        rate_d    = rate_reg;
        cnt_d     = cnt;
        idx_d     = idx;
        tri_d     = tri_val;
        dir_d     = tri_dir;
        sample_d  = sample;
        strobe_d  = 1'b0;
        wrap_d    = 1'b0;
        active_c  = run && (mode_c != MODE_HOLD);
        tick_c    = active_c && !rate_load && (cnt == rate_reg);
        idx_inc_c = idx + IDX_W'(1);

        if (rate_load) begin
            rate_d = rate;
            cnt_d  = '0;
        end else if (tick_c) begin
            cnt_d    = '0;
            idx_d    = idx_inc_c;
            strobe_d = 1'b1;
            wrap_d   = (idx == IDX_MAX);
            case (mode_c)
                MODE_TABLE: sample_d = tbl[idx_inc_c];
                MODE_TRI: begin
                    if (!tri_dir) begin
                        if (tri_val == SMP_MAX) begin
                            tri_d = SMP_MAX - SMP_W'(1);
                            dir_d = 1'b1;
                        end else begin
                            tri_d = tri_val + SMP_W'(1);
                        end
                    end else begin
                        if (tri_val == '0) begin
                            tri_d = SMP_W'(1);
                            dir_d = 1'b0;
                        end else begin
                            tri_d = tri_val - SMP_W'(1);
                        end
                    end
                    sample_d = tri_d;
                end
                MODE_SQUARE: sample_d = idx_inc_c[IDX_W-1] ? SMP_MAX : '0;
                default: ;
            endcase
        end else if (active_c) begin
            cnt_d = cnt + RATE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_reg      <= '0;
            cnt           <= '0;
            idx           <= '0;
            tri_val       <= '0;
            tri_dir       <= 1'b0;
            sample        <= '0;
            ext_data      <= 1'b0;
            sample_strobe <= 1'b0;
            wrap          <= 1'b0;
            for (int i = 0; i < int'(TBL_DEPTH); i++) begin
                tbl[i] <= '0;
            end
        end else begin
            rate_reg      <= rate_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            tri_val       <= tri_d;
            tri_dir       <= dir_d;
            sample        <= sample_d;
            ext_data      <= run;
            sample_strobe <= strobe_d;
            wrap          <= wrap_d;
            if (wr_en) begin
                tbl[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_r2r_wave_sequencer.sv
// Scoreboard bench for r2r_wave_sequencer: a tick-level reference model queues expected
// strobes; a negedge monitor checks sample, ext_data, strobe timing and wrap.
module tb_r2r_wave_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [1:0] mode;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] rate;
    logic       rate_load;
    logic [3:0] sample;
    logic       ext_data;
    logic       sample_strobe;
    logic       wrap;

    r2r_wave_sequencer #(.RATE_W(8), .TBL_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .run(run), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rate(rate), .rate_load(rate_load),
        .sample(sample), .ext_data(ext_data),
        .sample_strobe(sample_strobe), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [3:0] smp;
        logic       wrp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    bit   checking = 0;

    // Reference model state, kept at the level of the behavioural description.
    int         m_tbl [16];
    int         m_rate, m_cnt, m_idx, m_tri_n;
    logic [3:0] m_sample;
    logic       m_ext;

    // Triangle value after n triangle ticks: 0,1..15,14..1,0,... period 30.
    function automatic int tri_value(int n);
        int p;
        p = n % 30;
        return (p <= 15) ? p : 30 - p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 0;
        m_rate = 0; m_cnt = 0; m_idx = 0; m_tri_n = 0;
        m_sample = 4'd0; m_ext = 1'b0;
    endtask

    // Apply one clock edge with the inputs currently driven, and advance the model.
    task automatic cycle();
        bit         do_rst, active, tick;
        int         idx_inc;
        logic [3:0] smp;
        exp_t       e;
        do_rst  = rst;
        active  = run && (mode != 2'b11);
        tick    = !do_rst && active && !rate_load && (m_cnt == m_rate);
        idx_inc = (m_idx + 1) % 16;
        smp     = m_sample;
        if (tick) begin
            case (mode)
                2'b00:   smp = 4'(m_tbl[idx_inc]);
                2'b01:   smp = 4'(tri_value(m_tri_n + 1));
                default: smp = (idx_inc >= 8) ? 4'd15 : 4'd0;
            endcase
        end
        @(posedge clk);
        #1;
        edge_n++;
        if (do_rst) begin
            model_reset();
        end else begin
            if (rate_load) begin
                m_rate = int'(rate);
                m_cnt  = 0;
            end else if (tick) begin
                e.edge_no = edge_n;
                e.smp     = smp;
                e.wrp     = (m_idx == 15);
                exp_q.push_back(e);
                m_cnt    = 0;
                m_idx    = idx_inc;
                m_sample = smp;
                if (mode == 2'b01) m_tri_n = (m_tri_n + 1) % 30;
            end else if (active) begin
                m_cnt++;
            end
            if (wr_en) m_tbl[wr_addr] = int'(wr_data);
            m_ext = run;
        end
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        cycles(n);
        rst = 1'b0;
    endtask

    task automatic load_rate(int r);
        rate = 8'(r);
        rate_load = 1'b1;
        cycle();
        rate_load = 1'b0;
    endtask

    // Advance until the next edge is a tick edge (run=1, mode!=11 assumed).
    task automatic run_to_tick();
        for (int i = 0; i < 300; i++) begin
            if (m_cnt == m_rate) break;
            cycle();
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            exp_t e;
            tests++;
            if (sample !== m_sample) begin
                fails++;
                $display("FAIL sample edge %0d: got %0d expected %0d", edge_n, sample, m_sample);
            end
            tests++;
            if (ext_data !== m_ext) begin
                fails++;
                $display("FAIL ext_data edge %0d: got %0b expected %0b", edge_n, ext_data, m_ext);
            end
            if (sample_strobe === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe edge %0d: got strobe expected none", edge_n);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_no != edge_n || e.smp !== sample || e.wrp !== wrap) begin
                        fails++;
                        $display("FAIL strobe edge %0d: got sample=%0d wrap=%0b expected edge %0d sample=%0d wrap=%0b",
                                 edge_n, sample, wrap, e.edge_no, e.smp, e.wrp);
                    end
                end
            end else begin
                tests++;
                if (sample_strobe !== 1'b0 || wrap !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_pulses edge %0d: got strobe=%0b wrap=%0b expected 0 0",
                             edge_n, sample_strobe, wrap);
                end
                if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
                    e = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_strobe edge %0d: got no strobe expected sample=%0d", edge_n, e.smp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; mode = 2'b00; wr_en = 1'b0;
        wr_addr = 4'd0; wr_data = 4'd0; rate = 8'd0; rate_load = 1'b0;
        model_reset();

        // Reset then idle; an untouched table plays back as zeros.
        cycle();
        checking = 1;
        do_reset(1);
        cycles(5);
        run = 1'b1;
        cycles(20);

        // Table playback at rate 3.
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(15 - i);
            cycle();
        end
        wr_en = 1'b0;
        load_rate(3);
        mode = 2'b00; run = 1'b1;
        cycles(80);

        // Triangle from reset at one tick per cycle.
        do_reset(1);
        mode = 2'b01; run = 1'b1;
        cycles(70);

        // Square at rate 1.
        load_rate(1);
        mode = 2'b10;
        cycles(50);

        // Freeze with run=0, then hold with mode=11.
        run = 1'b0; cycles(10);
        run = 1'b1; cycles(10);
        mode = 2'b11; cycles(10);
        mode = 2'b10; cycles(10);

        // Edge events: write to the address about to be read, rate load on a tick edge.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(15 - i);
            cycle();
        end
        wr_en = 1'b0;
        load_rate(2);
        mode = 2'b00; run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_to_tick();
            wr_en = 1'b1;
            wr_addr = 4'((m_idx + 1) % 16);
            wr_data = ~4'(m_tbl[(m_idx + 1) % 16]);
            cycle();
            wr_en = 1'b0;
            cycles(5);
        end
        run_to_tick();
        load_rate(4);
        cycles(20);
        run_to_tick();
        load_rate(0);
        cycles(10);
        rst = 1'b1; cycle(); rst = 1'b0;
        cycles(5);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            run       = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            wr_en     = ($urandom_range(0, 9) < 3);
            wr_addr   = 4'($urandom_range(0, 15));
            wr_data   = 4'($urandom_range(0, 15));
            rate_load = ($urandom_range(0, 19) == 0);
            rate      = 8'($urandom_range(0, 5));
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; rate_load = 1'b0; wr_en = 1'b0;
        cycles(3);

        @(negedge clk);
        #1;
        checking = 0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_strobes: got %0d unmatched expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/r2r_wave_sequencer.md
Name: r2r_wave_sequencer

Overview:
Upstream sample source for the 4-bit R2R DAC control stage. Generates a periodic 4-bit sample stream from one of three sources:
- a 16-entry user-loadable waveform table
- a built-in triangle
- a built-in square

A programmable tick divider paces the stream. Outputs drive the DAC control's data[3:0] and ext_data inputs directly.

Parameters:
RATE_W, 8, width of the tick-rate divider register and counter
TBL_DEPTH, 16, waveform table entries (fixed power of two; index width = log2)

Ports:
clk  input  1  system clock (10 MHz nominal)
rst  input  1  synchronous active-high reset
run  input  1  1 = sequencer advances; 0 = freeze
mode  input  2  00 table, 01 triangle, 10 square, 11 hold
wr_en  input  1  write strobe for the waveform table
wr_addr  input  4  table write address
wr_data  input  4  table write data
rate  input  RATE_W  tick period minus one
rate_load  input  1  latch rate into rate_reg
sample  output  4  current sample, connects to DAC data[3:0]
ext_data  output  1  registered copy of run, connects to DAC ext_data
sample_strobe  output  1  one-cycle pulse when sample updates
wrap  output  1  one-cycle pulse when phase index wraps 15->0

Behaviour:
- Reset (rst=1 at posedge) clears the following to 0:
  - all outputs
  - rate_reg, tick counter cnt, phase index idx
  - triangle value tri, direction dir (0 = up)
  - all 16 table entries
- Reset overrides all other inputs, including mid-operation.
- rate_load=1: rate_reg <= rate and cnt <= 0 in the same edge, regardless of run. That edge produces no tick.
- ext_data <= run every cycle.
- Tick condition: run=1, mode!=11, rate_load=0, cnt==rate_reg.
  - rate_reg=0 gives a tick every cycle.
  - Tick period is rate_reg+1 cycles.
- Non-tick edges with run=1 and mode!=11: cnt <= cnt+1.
- run=0 or mode=11: cnt, idx, tri, dir and sample hold; no strobes.
- On a tick edge (all registered; sample visible 1 cycle after the edge where cnt==rate_reg):
  - cnt <= 0; idx <= idx+1 (mod 16); sample_strobe <= 1.
  - wrap <= 1 iff idx was 15.
  - mode 00: sample <= table[idx+1], using the table value before any same-edge write.
  - mode 01: tri steps by +1 if dir=0, else -1.
    - At tri=15 with dir=0: tri <= 14, dir <= 1.
    - At tri=0 with dir=1: tri <= 1, dir <= 0.
    - sample <= new tri.
    - Sequence 0,1..15,14..1,0,1..; period 30 ticks.
  - mode 10: sample <= 15 if (idx+1)[3]=1, else 0. Period 16 ticks, 50% duty.
- Triangle state (tri, dir) advances only on mode-01 ticks; other modes leave it untouched.
- Mode change takes effect at the next tick. idx is not reset; sample holds until then.
- Table write (wr_en=1) is accepted every cycle, independent of run/mode.
  - Write data becomes readable from the next edge.
  - Same-edge write and read of the same address returns the old data.
- sample_strobe and wrap are 0 on every non-tick edge.
- Counter widths wrap naturally. cnt never exceeds rate_reg, because rate_load clears it.

Test Plan:
- Reset then idle:
  - Stimulus: rst 2 cycles, run=0.
  - Response: sample=0, ext_data=0, no strobes; the table reads 0 when later played in mode 00.
- Table playback:
  - Stimulus: write table[i]=15-i for i=0..15; rate=3 with rate_load; mode=00; run=1.
  - Response: sample_strobe every 4 cycles; sample sequence 14,13..0,15,14..; wrap pulses with the strobe that emits 15.
- Triangle:
  - Stimulus: rate_reg=0, mode=01, run=1, 40 cycles.
  - Response: sample 1,2..15,14..0,1..; period 30; a strobe every cycle.
- Square:
  - Stimulus: rate_reg=1, mode=10.
  - Response: 0 for 7 ticks (idx 1..7), 15 for 8 ticks, then 0 for 8 ticks; a strobe every 2 cycles.
- Freeze and hold:
  - Stimulus: deassert run mid-stream for 10 cycles, then resume; repeat with mode=11.
  - Response: sample, idx and cnt are unchanged and no strobes occur during the freeze; ext_data follows run one cycle late.
- Edge events:
  - Stimulus 1: write to table[idx+1] on the tick edge.
  - Response 1: the old value is emitted.
  - Stimulus 2: rate_load on the tick edge.
  - Response 2: no tick; cnt=0; next tick after new rate+1 cycles.
  - Stimulus 3: rst asserted mid-run.
  - Response 3: everything 0 the next cycle.
